// File: rtl/wb_line_master_pkg.sv
// Shared types and width helpers for the Wishbone cache-line master.
package wb_line_master_pkg;

    localparam int unsigned WB_ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB_REQ,
        ST_FILL_REQ,
        ST_BACKOFF,
        ST_RESP
    } state_e;

    function automatic int unsigned sel_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned ofs_bits(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/wb_line_master_xfer_timer.sv
// Per-transfer retry and wait counters; flags are registered off the next count.
module wb_line_master_xfer_timer #(
    parameter int unsigned MAX_RETRY = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic retry_clr_i,
    input  logic retry_inc_i,
    input  logic wait_clr_i,
    input  logic wait_inc_i,
    output logic retry_exhausted_o,
    output logic wait_expired_o
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
    localparam int unsigned WAIT_W  = 16;

    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    always_comb begin
        retry_d = retry_q;
        wait_d  = wait_q;
        if (retry_clr_i) begin
            retry_d = '0;
        end else if (retry_inc_i) begin
            retry_d = retry_q + RETRY_W'(1);
        end
        if (wait_clr_i) begin
            wait_d = '0;
        end else if (wait_inc_i) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    // Expired marks the last allowed strobe cycle, so stb stays high exactly TIMEOUT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retry_q           <= '0;
            wait_q            <= '0;
            retry_exhausted_o <= 1'b0;
            wait_expired_o    <= 1'b0;
        end else begin
            retry_q           <= retry_d;
            wait_q            <= wait_d;
            retry_exhausted_o <= (retry_d == RETRY_W'(MAX_RETRY));
            wait_expired_o    <= (wait_d == WAIT_W'(TIMEOUT - 1));
        end
    end

endmodule

// File: rtl/wb_line_master.sv
// Wishbone B4 classic master: optional victim writeback, then line fill, with retry/timeout.
module wb_line_master
    import wb_line_master_pkg::*;
#(
    parameter int unsigned CACHE_WIDTH = 128,
    parameter int unsigned MAX_RETRY   = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [WB_ADDR_W-1:0]                req_fill_addr,
    input  logic                                req_wb,
    input  logic [WB_ADDR_W-1:0]                req_wb_addr,
    input  logic [CACHE_WIDTH-1:0]              req_wb_data,
    output logic                                resp_valid,
    output logic [CACHE_WIDTH-1:0]              resp_data,
    output logic                                resp_err,
    output logic [WB_ADDR_W-1:0]                wb_adr_o,
    output logic [CACHE_WIDTH-1:0]              wb_dat_o,
    input  logic [CACHE_WIDTH-1:0]              wb_dat_i,
    output logic                                wb_we_o,
    output logic [sel_width(CACHE_WIDTH)-1:0]   wb_sel_o,
    output logic                                wb_stb_o,
    output logic                                wb_cyc_o,
    input  logic                                wb_ack_i,
    input  logic                                wb_err_i,
    input  logic                                wb_rty_i
);

    localparam int unsigned SEL_WIDTH = sel_width(CACHE_WIDTH);
    localparam int unsigned OFS_BITS  = ofs_bits(CACHE_WIDTH);
    localparam logic [WB_ADDR_W-1:0] ADR_MASK =
        ~((WB_ADDR_W'(1) << OFS_BITS) - WB_ADDR_W'(1));

    state_e state_q, state_d, resume_q, resume_d;
    logic [WB_ADDR_W-1:0]   fill_adr_q, fill_adr_d, vic_adr_q, vic_adr_d, adr_d;
    logic [CACHE_WIDTH-1:0] vic_dat_q, vic_dat_d, dat_d, resp_data_d;
    logic [SEL_WIDTH-1:0]   sel_d;
    logic resp_err_d, cyc_d, we_d, resp_valid_d, ready_d;
    logic retry_clr_c, retry_inc_c, wait_clr_c, wait_inc_c;
    logic retry_exhausted, wait_expired;

    wb_line_master_xfer_timer #(
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) u_timer (
        .clk               (clk),
        .rst               (rst),
        .retry_clr_i       (retry_clr_c),
        .retry_inc_i       (retry_inc_c),
        .wait_clr_i        (wait_clr_c),
        .wait_inc_i        (wait_inc_c),
        .retry_exhausted_o (retry_exhausted),
        .wait_expired_o    (wait_expired)
    );

    // Next-state, captured request fields and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        fill_adr_d  = fill_adr_q;
        vic_adr_d   = vic_adr_q;
        vic_dat_d   = vic_dat_q;
        resp_data_d = resp_data;
        resp_err_d  = resp_err;
        retry_clr_c = 1'b0;
        retry_inc_c = 1'b0;
        wait_clr_c  = 1'b0;
        wait_inc_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    fill_adr_d  = req_fill_addr & ADR_MASK;
                    vic_adr_d   = req_wb_addr & ADR_MASK;
                    vic_dat_d   = req_wb_data;
                    state_d     = req_wb ? ST_WB_REQ : ST_FILL_REQ;
                    retry_clr_c = 1'b1;
                    wait_clr_c  = 1'b1;
                end
            end
            ST_WB_REQ, ST_FILL_REQ: begin
                if (wb_err_i) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                end else if (wb_ack_i) begin
                    if (state_q == ST_WB_REQ) begin
                        // One idle bus cycle separates writeback from fill.
                        state_d     = ST_BACKOFF;
                        resume_d    = ST_FILL_REQ;
                        retry_clr_c = 1'b1;
                    end else begin
                        state_d     = ST_RESP;
                        resp_data_d = wb_dat_i;
                        resp_err_d  = 1'b0;
                    end
                end else if (wb_rty_i) begin
                    if (retry_exhausted) begin
                        state_d    = ST_RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        retry_inc_c = 1'b1;
                        resume_d    = state_q;
                        state_d     = ST_BACKOFF;
                    end
                end else if (wait_expired) begin
                    state_d    = ST_RESP;
                    resp_err_d = 1'b1;
                end else begin
                    wait_inc_c = 1'b1;
                end
            end
            ST_BACKOFF: begin
                state_d    = resume_q;
                wait_clr_c = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cyc_d        = (state_d == ST_WB_REQ) || (state_d == ST_FILL_REQ);
        we_d         = (state_d == ST_WB_REQ);
        sel_d        = cyc_d ? '1 : '0;
        adr_d        = (state_d == ST_WB_REQ)   ? vic_adr_d  :
                       (state_d == ST_FILL_REQ) ? fill_adr_d : wb_adr_o;
        dat_d        = (state_d == ST_WB_REQ)   ? vic_dat_d  : wb_dat_o;
        resp_valid_d = (state_d == ST_RESP);
        ready_d      = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            resume_q   <= ST_IDLE;
            fill_adr_q <= '0;
            vic_adr_q  <= '0;
            vic_dat_q  <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_data  <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            fill_adr_q <= fill_adr_d;
            vic_adr_q  <= vic_adr_d;
            vic_dat_q  <= vic_dat_d;
            req_ready  <= ready_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_data  <= resp_data_d;
            wb_cyc_o   <= cyc_d;
            wb_stb_o   <= cyc_d;
            wb_we_o    <= we_d;
            wb_adr_o   <= adr_d;
            wb_dat_o   <= dat_d;
            wb_sel_o   <= sel_d;
        end
    end

endmodule

// File: doc/wb_line_master.md
Name: wb_line_master

Overview:
- Wishbone B4 classic bus master for cache-line traffic; sits between the cache/memory controller and the cpu top-level wb_* master port.
- Accepts one miss request at a time.
- Optionally writes back a dirty victim line first, then fills the requested line.
- Handles retry, error and timeout, and returns the filled line or an error to the cache.

Parameters:
- CACHE_WIDTH, 128, line/bus data width in bits (power of two, ≥32).
- MAX_RETRY, 4, number of rty_i responses tolerated per transfer before failing.
- TIMEOUT, 255, cycles a transfer may wait for ack/err/rty before failing (1..65535).
- SEL_WIDTH (localparam), CACHE_WIDTH/8.
- OFS_BITS (localparam), log2(SEL_WIDTH).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request present.
- req_ready  out  1  block idle and able to accept a request.
- req_fill_addr  in  32  byte address of line to fill.
- req_wb  in  1  victim writeback required before fill.
- req_wb_addr  in  32  byte address of victim line.
- req_wb_data  in  CACHE_WIDTH  victim line data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  CACHE_WIDTH  filled line, valid with resp_valid.
- resp_err  out  1  transaction failed, valid with resp_valid.
- wb_adr_o  out  32  line address.
- wb_dat_o  out  CACHE_WIDTH  write data.
- wb_dat_i  in  CACHE_WIDTH  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  SEL_WIDTH  byte selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  ack.
- wb_err_i  in  1  error.
- wb_rty_i  in  1  retry.

Behaviour:
- Reset values: state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_data=0; wb_cyc_o=0; wb_stb_o=0; wb_we_o=0; wb_adr_o=0; wb_dat_o=0; wb_sel_o=0; all counters 0.
- Reset mid-transfer drops cyc/stb asynchronously and abandons the request; no response is issued.
- Request acceptance:
  - Accepted when req_valid && req_ready; req_ready = (state==IDLE).
  - All request fields are registered at acceptance; inputs may change afterwards.
  - Low OFS_BITS of both addresses are forced to 0 on wb_adr_o.
- States:
  - IDLE -> WB_REQ if req_wb, else FILL_REQ.
  - WB_REQ: cyc=stb=we=1, sel=all ones, dat_o=victim data, adr=victim address.
  - FILL_REQ: cyc=stb=1, we=0, sel=all ones, adr=fill address.
  - BACKOFF: cyc=stb=0 for exactly one cycle, then re-enters the same request state it came from.
  - RESP: resp_valid=1 for one cycle, then -> IDLE.
- Cycle timing: cyc/stb assert the cycle after acceptance (registered outputs). They stay high, with constant adr/dat/we/sel, until ack, err, rty or timeout is sampled.
- Transfer termination (priority err > ack > rty):
  - ack in WB_REQ -> FILL_REQ. cyc/stb deassert for one cycle between the two transfers; no back-to-back.
  - ack in FILL_REQ -> capture wb_dat_i into resp_data; -> RESP with resp_err=0.
  - err -> RESP with resp_err=1. A writeback error skips the fill.
  - rty -> retry_cnt++ and -> BACKOFF.
    - If retry_cnt already equals MAX_RETRY, the rty instead -> RESP with resp_err=1.
    - retry_cnt clears when a new transfer (WB or FILL) begins.
- Timeout:
  - wait_cnt counts cycles with stb high and no termination.
  - When wait_cnt reaches TIMEOUT: drop cyc/stb next cycle, -> RESP with resp_err=1.
  - wait_cnt clears on every stb assertion.
- resp_data on error holds its previous value.
- The block tolerates ack arriving in the same cycle stb first rises (zero-wait slave): one-cycle transfer.
- Termination signals sampled while stb=0 are ignored.

Decomposition:
- Shared package (cpu_pkg): state encoding enum (IDLE, WB_REQ, FILL_REQ, BACKOFF, RESP) and the Wishbone width constants (address width 32, SEL_WIDTH derivation).
- One natural sub-module: wb_xfer_timer, holding the retry counter and the timeout counter, with clear/inc/expired outputs.
- FSM and datapath registers stay in wb_line_master.

Test Plan:
- Clean fill: req_fill_addr=0x0000_1238, req_wb=0. Slave acks after 2 wait states with data 0xDEADBEEF_...
  -> wb_adr_o=0x0000_1230, we=0, sel=0xFFFF; resp_valid pulse with that data, resp_err=0; req_ready returns high the next cycle.
- Writeback then fill: req_wb=1, wb_addr=0x2000, fill_addr=0x3000.
  -> write cycle at 0x2000 with we=1 and victim data, ack; one idle bus cycle; read at 0x3000; resp_err=0.
- Retry: slave answers rty 3 times, then ack (MAX_RETRY=4).
  -> 3 BACKOFF gaps of exactly one cycle; success response.
  -> With 5 consecutive rty: resp_err=1 after the 5th.
- Error in writeback: err on the WB transfer.
  -> no fill cycle issued; resp_valid with resp_err=1.
- Timeout: TIMEOUT=8, slave never responds.
  -> stb high for exactly 8 cycles, cyc drops, resp_err=1.
- Async reset asserted mid-FILL_REQ (between clock edges).
  -> cyc/stb low immediately; req_ready=1 after release; no resp_valid.
